// File: rtl/aes_pipe_arbiter.sv
// aes_pipe_arbiter: round-robin front end sharing a fixed-latency AES pipe between two
// requesters, with credit-guarded per-channel result FIFOs fed by a tag delay line.
module aes_pipe_arbiter #(
    parameter int LENGTH     = 128,
    parameter int PIPE_LAT   = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic              in1_valid,
    output logic              in0_ready,
    output logic              in1_ready,
    input  logic [LENGTH-1:0] in0_text,
    input  logic [LENGTH-1:0] in1_text,
    input  logic [LENGTH-1:0] in0_key,
    input  logic [LENGTH-1:0] in1_key,
    output logic              out0_valid,
    output logic              out1_valid,
    input  logic              out0_ready,
    input  logic              out1_ready,
    output logic [LENGTH-1:0] out0_data,
    output logic [LENGTH-1:0] out1_data,
    output logic              pipe_vld,
    output logic [LENGTH-1:0] pipe_text,
    output logic [LENGTH-1:0] pipe_key,
    input  logic [LENGTH-1:0] pipe_ct,
    output logic              busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [1:0]          in_valid, out_ready, elig, grant, push, pop;
    logic [CW-1:0]       cnt_q [2];
    logic [CW-1:0]       cnt_d [2];
    logic [CW-1:0]       fcnt_q [2];
    logic [CW-1:0]       fcnt_d [2];
    logic [PW-1:0]       wp_q [2];
    logic [PW-1:0]       rp_q [2];
    logic [LENGTH-1:0]   mem_q [2][FIFO_DEPTH];
    logic [PIPE_LAT-1:0] tv_q, tc_q;
    logic                last_q, last_d, pipe_vld_q, pipe_ch_q;
    logic [LENGTH-1:0]   pipe_text_q, pipe_text_d, pipe_key_q, pipe_key_d;

    assign in_valid  = {in1_valid, in0_valid};
    assign out_ready = {out1_ready, out0_ready};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = in_valid[i] && (cnt_q[i] < FULL);
            push[i] = tv_q[PIPE_LAT-1] && (tc_q[PIPE_LAT-1] == i[0]);
            pop[i]  = out_ready[i] && (fcnt_q[i] != '0);
        end
        grant[0] = elig[0] && (!elig[1] || last_q);
        grant[1] = elig[1] && (!elig[0] || !last_q);
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]  = cnt_q[i] + CW'(grant[i]) - CW'(pop[i]);
            fcnt_d[i] = fcnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
        last_d      = (|grant) ? grant[1] : last_q;
        pipe_text_d = grant[1] ? in1_text : grant[0] ? in0_text : pipe_text_q;
        pipe_key_d  = grant[1] ? in1_key : grant[0] ? in0_key : pipe_key_q;
    end

    // The tag line is fed from the issue register so its head lines up with pipe_ct.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= '0;
                fcnt_q[i] <= '0;
                wp_q[i]   <= '0;
                rp_q[i]   <= '0;
            end
            tv_q        <= '0;
            tc_q        <= '0;
            last_q      <= 1'b1;
            pipe_vld_q  <= 1'b0;
            pipe_ch_q   <= 1'b0;
            pipe_text_q <= '0;
            pipe_key_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= cnt_d[i];
                fcnt_q[i] <= fcnt_d[i];
                wp_q[i]   <= wp_q[i] + PW'(push[i]);
                rp_q[i]   <= rp_q[i] + PW'(pop[i]);
            end
            tv_q        <= {tv_q[PIPE_LAT-2:0], pipe_vld_q};
            tc_q        <= {tc_q[PIPE_LAT-2:0], pipe_ch_q};
            last_q      <= last_d;
            pipe_vld_q  <= |grant;
            pipe_ch_q   <= grant[1];
            pipe_text_q <= pipe_text_d;
            pipe_key_q  <= pipe_key_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (push[i]) mem_q[i][wp_q[i]] <= pipe_ct;
    end

    assign in0_ready  = grant[0];
    assign in1_ready  = grant[1];
    assign out0_valid = fcnt_q[0] != '0;
    assign out1_valid = fcnt_q[1] != '0;
    assign out0_data  = mem_q[0][rp_q[0]];
    assign out1_data  = mem_q[1][rp_q[1]];
    assign pipe_vld   = pipe_vld_q;
    assign pipe_text  = pipe_text_q;
    assign pipe_key   = pipe_key_q;
    assign busy       = pipe_vld_q || (|tv_q) || out0_valid || out1_valid;
endmodule

// File: tb/tb_aes_pipe_arbiter.sv
// tb_aes_pipe_arbiter: randomized bench with a queue-based reference model of the
// arbiter/credit/FIFO behaviour and a delay-line stand-in for the AES core.
module tb_aes_pipe_arbiter;
    localparam int L  = 128;
    localparam int PL = 12;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in0_valid = 1'b0, in1_valid = 1'b0, out0_ready = 1'b0, out1_ready = 1'b0;
    logic in0_ready, in1_ready, out0_valid, out1_valid, pipe_vld, busy;
    logic [L-1:0] in0_text = '0, in1_text = '0, in0_key = '0, in1_key = '0;
    logic [L-1:0] out0_data, out1_data, pipe_text, pipe_key, pipe_ct;
    logic [L-1:0] core_q [PL];

    typedef struct {
        logic [L-1:0] d;
        int           acc;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int           cyc, checks, failures, mlast;
    logic         mpv;
    logic [L-1:0] mtext, mkey;

    aes_pipe_arbiter #(.LENGTH(L), .PIPE_LAT(PL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in1_valid(in1_valid),
        .in0_ready(in0_ready), .in1_ready(in1_ready),
        .in0_text(in0_text), .in1_text(in1_text),
        .in0_key(in0_key), .in1_key(in1_key),
        .out0_valid(out0_valid), .out1_valid(out1_valid),
        .out0_ready(out0_ready), .out1_ready(out1_ready),
        .out0_data(out0_data), .out1_data(out1_data),
        .pipe_vld(pipe_vld), .pipe_text(pipe_text), .pipe_key(pipe_key),
        .pipe_ct(pipe_ct), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [L-1:0] enc(input logic [L-1:0] t, input logic [L-1:0] k);
        return {t[L/2-1:0], t[L-1:L/2]} ^ k ^ {(L/8){8'h5a}};
    endfunction

    always @(posedge clk) begin
        core_q[0] <= enc(pipe_text, pipe_key);
        for (int i = 1; i < PL; i++) core_q[i] <= core_q[i-1];
    end
    assign pipe_ct = core_q[PL-1];

    function automatic logic [L-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        mlast = 1;
        mpv   = 1'b0;
        mtext = '0;
        mkey  = '0;
        cyc   = 0;
    endfunction

    function automatic bit exp_rdy(int c);
        bit e0, e1;
        e0 = in0_valid && (q0.size() < FD);
        e1 = in1_valid && (q1.size() < FD);
        if (c == 0) return e0 && (!e1 || mlast == 1);
        return e1 && (!e0 || mlast == 0);
    endfunction

    function automatic bit exp_ov(int c);
        if (c == 0) begin
            if (q0.size() == 0) return 1'b0;
            return q0[0].acc + PL + 2 <= cyc;
        end
        if (q1.size() == 0) return 1'b0;
        return q1[0].acc + PL + 2 <= cyc;
    endfunction

    function automatic logic [L-1:0] exp_od(int c);
        return (c == 0) ? q0[0].d : q1[0].d;
    endfunction

    function automatic bit exp_busy();
        bit b;
        b = 1'b0;
        if (q0.size() > 0) b = b || (q0[0].acc < cyc);
        if (q1.size() > 0) b = b || (q1[0].acc < cyc);
        return b;
    endfunction

    task automatic tick();
        bit a0, a1, p0, p1;
        a0 = in0_valid && exp_rdy(0);
        a1 = in1_valid && exp_rdy(1);
        p0 = out0_ready && exp_ov(0);
        p1 = out1_ready && exp_ov(1);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (a0) q0.push_back('{d: enc(in0_text, in0_key), acc: cyc});
        if (a1) q1.push_back('{d: enc(in1_text, in1_key), acc: cyc});
        if (a0 || a1) begin
            mlast = a1 ? 1 : 0;
            mtext = a1 ? in1_text : in0_text;
            mkey  = a1 ? in1_key : in0_key;
        end
        mpv = a0 || a1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks += 6;
        if (out0_valid !== 1'b0) begin failures++; $display("FAIL reset_out0_valid got=%b exp=0", out0_valid); end
        if (out1_valid !== 1'b0) begin failures++; $display("FAIL reset_out1_valid got=%b exp=0", out1_valid); end
        if (pipe_vld !== 1'b0) begin failures++; $display("FAIL reset_pipe_vld got=%b exp=0", pipe_vld); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (pipe_text !== '0) begin failures++; $display("FAIL reset_pipe_text got=%h exp=0", pipe_text); end
        if (pipe_key !== '0) begin failures++; $display("FAIL reset_pipe_key got=%h exp=0", pipe_key); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [L-1:0] t, k;
        t = rnd();
        k = rnd();
        apply_reset();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            in0_valid = (cyc == 5);
            in0_text  = t;
            in0_key   = k;
            #1;
            checks += 3;
            if (pipe_vld !== (cyc == 6)) begin failures++; $display("FAIL single_pipe_vld cyc=%0d got=%b", cyc, pipe_vld); end
            if (out0_valid !== (cyc == 5 + PL + 2)) begin failures++; $display("FAIL single_out0_valid cyc=%0d got=%b", cyc, out0_valid); end
            if (busy !== (cyc >= 6 && cyc <= 5 + PL + 2)) begin failures++; $display("FAIL single_busy cyc=%0d got=%b", cyc, busy); end
            if (cyc == 5) begin
                checks++;
                if (in0_ready !== 1'b1) begin failures++; $display("FAIL single_in0_ready got=%b exp=1", in0_ready); end
            end
            if (cyc == 6) begin
                checks++;
                if (pipe_text !== t) begin failures++; $display("FAIL single_pipe_text got=%h exp=%h", pipe_text, t); end
            end
            if (cyc == 5 + PL + 2) begin
                checks++;
                if (out0_data !== enc(t, k)) begin failures++; $display("FAIL single_out0_data got=%h exp=%h", out0_data, enc(t, k)); end
            end
            tick();
        end
        in0_valid = 1'b0;
    endtask

    task automatic test_alternate();
        int prev;
        prev = -1;
        apply_reset();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            in0_valid = 1'b1;
            in1_valid = 1'b1;
            in0_text = rnd(); in0_key = rnd();
            in1_text = rnd(); in1_key = rnd();
            #1;
            if (n < 8) begin
                checks += 2;
                if (in0_ready !== (n % 2 == 0)) begin failures++; $display("FAIL alt_first_in0_ready n=%0d got=%b", n, in0_ready); end
                if (in1_ready !== (n % 2 == 1)) begin failures++; $display("FAIL alt_first_in1_ready n=%0d got=%b", n, in1_ready); end
            end
            checks += 2;
            if (in0_ready !== exp_rdy(0)) begin failures++; $display("FAIL alt_in0_ready cyc=%0d got=%b exp=%b", cyc, in0_ready, exp_rdy(0)); end
            if (in1_ready !== exp_rdy(1)) begin failures++; $display("FAIL alt_in1_ready cyc=%0d got=%b exp=%b", cyc, in1_ready, exp_rdy(1)); end
            if (in0_ready || in1_ready) begin
                if (prev >= 0) begin
                    checks++;
                    if (int'(in1_ready) == prev) begin failures++; $display("FAIL alt_order cyc=%0d got=ch%0d exp=ch%0d", cyc, in1_ready, 1 - prev); end
                end
                prev = int'(in1_ready);
            end
            if (exp_ov(0)) begin
                checks++;
                if (out0_data !== exp_od(0)) begin failures++; $display("FAIL alt_out0_data got=%h exp=%h", out0_data, exp_od(0)); end
            end
            if (exp_ov(1)) begin
                checks++;
                if (out1_data !== exp_od(1)) begin failures++; $display("FAIL alt_out1_data got=%h exp=%h", out1_data, exp_od(1)); end
            end
            tick();
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic test_credit();
        int acc0, popcyc;
        acc0 = 0;
        popcyc = -1;
        apply_reset();
        out1_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            in0_valid  = 1'b1;
            in1_valid  = $urandom_range(0, 1) == 1;
            out0_ready = (cyc == popcyc);
            in0_text = rnd(); in0_key = rnd();
            in1_text = rnd(); in1_key = rnd();
            #1;
            checks += 4;
            if (in0_ready !== exp_rdy(0)) begin failures++; $display("FAIL credit_in0_ready cyc=%0d got=%b exp=%b", cyc, in0_ready, exp_rdy(0)); end
            if (in1_ready !== exp_rdy(1)) begin failures++; $display("FAIL credit_in1_ready cyc=%0d got=%b exp=%b", cyc, in1_ready, exp_rdy(1)); end
            if (out0_valid !== exp_ov(0)) begin failures++; $display("FAIL credit_out0_valid cyc=%0d got=%b exp=%b", cyc, out0_valid, exp_ov(0)); end
            if (out1_valid !== exp_ov(1)) begin failures++; $display("FAIL credit_out1_valid cyc=%0d got=%b exp=%b", cyc, out1_valid, exp_ov(1)); end
            if (exp_ov(1)) begin
                checks++;
                if (out1_data !== exp_od(1)) begin failures++; $display("FAIL credit_out1_data got=%h exp=%h", out1_data, exp_od(1)); end
            end
            if (in0_valid && in0_ready) acc0++;
            tick();
            if (popcyc < 0 && q0.size() == FD) popcyc = q0[FD-1].acc + PL + 1;
        end
        checks++;
        if (acc0 !== FD + 1) begin failures++; $display("FAIL credit_accepts got=%0d exp=%0d", acc0, FD + 1); end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic test_drain(input int n);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in0_valid  = 1'b0;
        in1_valid  = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            checks += 3;
            if (out0_valid !== exp_ov(0)) begin failures++; $display("FAIL drain_out0_valid cyc=%0d got=%b exp=%b", cyc, out0_valid, exp_ov(0)); end
            if (out1_valid !== exp_ov(1)) begin failures++; $display("FAIL drain_out1_valid cyc=%0d got=%b exp=%b", cyc, out1_valid, exp_ov(1)); end
            if (busy !== exp_busy()) begin failures++; $display("FAIL drain_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            if (exp_ov(0)) begin
                checks++;
                if (out0_data !== exp_od(0)) begin failures++; $display("FAIL drain_out0_data got=%h exp=%h", out0_data, exp_od(0)); end
            end
            if (exp_ov(1)) begin
                checks++;
                if (out1_data !== exp_od(1)) begin failures++; $display("FAIL drain_out1_data got=%h exp=%h", out1_data, exp_od(1)); end
            end
            tick();
        end
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL drain_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            in0_valid  = $urandom_range(0, 3) != 0;
            in1_valid  = $urandom_range(0, 3) != 0;
            out0_ready = $urandom_range(0, 3) != 0;
            out1_ready = $urandom_range(0, 2) == 0;
            in0_text = rnd(); in0_key = rnd();
            in1_text = rnd(); in1_key = rnd();
            #1;
            checks += 6;
            if (in0_ready !== exp_rdy(0)) begin failures++; $display("FAIL rand_in0_ready cyc=%0d got=%b exp=%b", cyc, in0_ready, exp_rdy(0)); end
            if (in1_ready !== exp_rdy(1)) begin failures++; $display("FAIL rand_in1_ready cyc=%0d got=%b exp=%b", cyc, in1_ready, exp_rdy(1)); end
            if (out0_valid !== exp_ov(0)) begin failures++; $display("FAIL rand_out0_valid cyc=%0d got=%b exp=%b", cyc, out0_valid, exp_ov(0)); end
            if (out1_valid !== exp_ov(1)) begin failures++; $display("FAIL rand_out1_valid cyc=%0d got=%b exp=%b", cyc, out1_valid, exp_ov(1)); end
            if (busy !== exp_busy()) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            if (pipe_vld !== mpv) begin failures++; $display("FAIL rand_pipe_vld cyc=%0d got=%b exp=%b", cyc, pipe_vld, mpv); end
            if (mpv) begin
                checks += 2;
                if (pipe_text !== mtext) begin failures++; $display("FAIL rand_pipe_text got=%h exp=%h", pipe_text, mtext); end
                if (pipe_key !== mkey) begin failures++; $display("FAIL rand_pipe_key got=%h exp=%h", pipe_key, mkey); end
            end
            if (exp_ov(0)) begin
                checks++;
                if (out0_data !== exp_od(0)) begin failures++; $display("FAIL rand_out0_data got=%h exp=%h", out0_data, exp_od(0)); end
            end
            if (exp_ov(1)) begin
                checks++;
                if (out1_data !== exp_od(1)) begin failures++; $display("FAIL rand_out1_data got=%h exp=%h", out1_data, exp_od(1)); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        logic [L-1:0] t, k;
        apply_reset();
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        in0_valid = 1'b1; in0_text = rnd(); in0_key = rnd();
        tick();
        in0_valid = 1'b0;
        repeat (PL + 2) tick();
        for (int n = 0; n < 3; n++) begin
            in0_valid = 1'b1; in0_text = rnd(); in0_key = rnd();
            tick();
        end
        in0_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks += 5;
        if (out0_valid !== 1'b0) begin failures++; $display("FAIL mid_out0_valid got=%b exp=0", out0_valid); end
        if (pipe_vld !== 1'b0) begin failures++; $display("FAIL mid_pipe_vld got=%b exp=0", pipe_vld); end
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        if (pipe_text !== '0) begin failures++; $display("FAIL mid_pipe_text got=%h exp=0", pipe_text); end
        if (pipe_key !== '0) begin failures++; $display("FAIL mid_pipe_key got=%h exp=0", pipe_key); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        out0_ready = 1'b1;
        for (int n = 0; n < PL + 6; n++) begin
            #1;
            checks += 3;
            if (out0_valid !== 1'b0) begin failures++; $display("FAIL mid_ghost_out0 cyc=%0d got=%b exp=0", cyc, out0_valid); end
            if (out1_valid !== 1'b0) begin failures++; $display("FAIL mid_ghost_out1 cyc=%0d got=%b exp=0", cyc, out1_valid); end
            if (busy !== 1'b0) begin failures++; $display("FAIL mid_ghost_busy cyc=%0d got=%b exp=0", cyc, busy); end
            tick();
        end
        t = rnd();
        k = rnd();
        for (int n = 0; n < PL + 4; n++) begin
            in1_valid = (n == 0);
            in1_text  = t;
            in1_key   = k;
            #1;
            checks++;
            if (out1_valid !== (n == PL + 2)) begin failures++; $display("FAIL mid_new_out1_valid n=%0d got=%b", n, out1_valid); end
            if (n == PL + 2) begin
                checks++;
                if (out1_data !== enc(t, k)) begin failures++; $display("FAIL mid_new_out1_data got=%h exp=%h", out1_data, enc(t, k)); end
            end
            tick();
        end
        in1_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_single();
        test_alternate();
        test_drain(30);
        test_credit();
        test_drain(30);
        test_random();
        test_drain(40);
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_pipe_arbiter.md
# aes_pipe_arbiter

Front-end controller for the fully pipelined 11-stage AES-128 encryption core. It shares the core between two independent requesters using round-robin arbitration with valid/ready handshakes. Each issued block is tracked by a tag delay line that matches the core's fixed latency, and the returning ciphertext is steered into a per-channel result FIFO. Per-channel credits guarantee that a result never arrives at a full FIFO, because the core itself cannot stall.

## Interface
Parameters:
- LENGTH, 128, block and key width in bits
- PIPE_LAT, 12, cycles from pipe_vld/pipe_text sampled to the matching pipe_ct valid at the core output
- FIFO_DEPTH, 4, result FIFO entries per channel; also the per-channel credit limit (power of 2, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in0_valid / in1_valid  in  1  request valid, channel 0/1
- in0_ready / in1_ready  out  1  request accepted this cycle when valid&&ready
- in0_text / in1_text  in  LENGTH  plaintext
- in0_key / in1_key  in  LENGTH  cipher key
- out0_valid / out1_valid  out  1  ciphertext available
- out0_ready / out1_ready  in  1  consumer pops on valid&&ready
- out0_data / out1_data  out  LENGTH  ciphertext (FIFO head)
- pipe_vld  out  1  registered; a block is presented to the core
- pipe_text  out  LENGTH  registered plaintext to the core
- pipe_key  out  LENGTH  registered key to the core
- pipe_ct  in  LENGTH  core ciphertext output
- busy  out  1  any tag in flight or any FIFO non-empty

## Operation
- Credit counter per channel, cnt_c, range 0..FIFO_DEPTH, width $clog2(FIFO_DEPTH+1). It counts blocks in flight plus blocks held in FIFO_c.
  - +1 on input accept, -1 on output pop; both in the same cycle leave it unchanged.
- Eligibility: elig_c = in_c_valid && (cnt_c < FIFO_DEPTH).
- Arbitration: at most one grant per cycle.
  - One eligible channel: it is granted.
  - Both eligible: grant the channel opposite last_grant; last_grant updates only on an actual grant.
  - in_c_ready = grant_c. This is combinational from in_*_valid and cnt_*; no path from the outputs back to it.
- Issue: on grant_c, at the next edge:
  - pipe_text ← in_c_text, pipe_key ← in_c_key, pipe_vld ← 1;
  - a tag {vld=1, ch=c} enters the tag delay line.
  - With no grant: pipe_vld ← 0, a {vld=0} tag enters, and pipe_text/pipe_key hold their values.
- Tag delay line: PIPE_LAT stages, shifting every cycle. When the head tag has vld=1, pipe_ct is written into FIFO[head.ch] at that edge.
- Result FIFOs: circular buffers with write/read pointers and an occupancy count.
  - out_c_valid = FIFO non-empty; out_c_data = head entry.
  - Simultaneous push and pop is legal at any occupancy, including full (pop frees the slot).
  - Push to a full FIFO is impossible by credit construction; the bench asserts this.
- Reset (asynchronous, any time):
  - cnt=0, FIFOs empty, all tags vld=0.
  - pipe_vld=0, pipe_text=0, pipe_key=0.
  - last_grant=1, so ch0 wins the first tie.
  - busy=0; all out_valid=0.
  - Blocks already inside the core are abandoned; their pipe_ct is ignored because their tags were cleared.

## Timing
- Accept in cycle T: pipe_vld high in T+1; pipe_ct captured at the end of cycle T+1+PIPE_LAT; out_c_valid high in T+2+PIPE_LAT if FIFO_c was empty. Total latency is PIPE_LAT+2.
- Sustained throughput: one block per cycle across both channels. With both channels saturated and consumers always ready, each channel gets one block every 2 cycles.
- Per-channel throughput is bounded by FIFO_DEPTH/(PIPE_LAT+2) when the consumer is slow: credits stall input, never output.
- Ordering: results return per channel in acceptance order. No ordering holds between channels.
- busy is combinational from the tag valids and FIFO counts.

## Test plan
Benches use a PIPE_LAT-deep behavioural delay-line model of the core unless noted; FIFO_DEPTH=4.
- Single request, ch0, in cycle 5; outputs always ready → pipe_vld in cycle 6; out0_valid in cycle 19 (PIPE_LAT=12) with the model's data; busy falls the cycle after the pop.
- Both valid continuously, distinct payloads, outputs ready → grants alternate ch0,ch1,ch0,…; ch0 gets the first grant after reset; each channel's outputs appear in its own submit order.
- ch0 output held not-ready, ch0 valid continuously → exactly 4 accepts, then in0_ready=0 while cnt0=4; one pop restores one accept in the same cycle the count would overflow, so cnt0 stays 4; ch1 traffic is unaffected throughout.
- Full FIFO with a simultaneous arriving result and pop (cnt=4, one pop coinciding with a tag arrival) → no overflow assertion; data order is preserved.
- Assert rst for 1 cycle with 3 blocks in flight and 1 in the FIFO → all outputs return to their reset values immediately; the later core outputs never appear; a new request completes normally in PIPE_LAT+2 cycles.
- With the real AES core: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff on ch1 → out1_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
